mole_game_ctrl: RTL and testbench
=================================

Name: mole_game_ctrl

Overview:
Parametrised whack-a-mole game controller and mole detector. It replaces the single-LED activate/detect pair with N_MOLES independent mole slots, up to MAX_ACTIVE simultaneous moles, per-mole lifetimes, miss-on-timeout and a round timer. It sits between the ms tick timer, the RNG, the debounced switch edges, and the score updater and display.

Parameters:
N_MOLES, 10, number of mole slots (LEDs/switches), 2..16
MAX_ACTIVE, 3, maximum simultaneously lit moles, 1..N_MOLES
LIFETIME_MS, 1500, ticks a mole stays lit before it expires
SPAWN_MS, 1000, ticks between spawn attempts
GAME_MS, 30000, round length in ticks
RNG_W, 5, width of rng_value

Ports:
clk  in  1  system clock (50 MHz)
rst_n  in  1  asynchronous active-low reset
tick  in  1  1-cycle pulse every 1 ms
start  in  1  1-cycle pulse; starts a round
rng_value  in  RNG_W  free-running random value
btn_edge  in  N_MOLES  rising-edge pulses from the debounced switches
moles  out  N_MOLES  level; currently lit moles (drives LEDR)
hit_pulse  out  1  1-cycle pulse; one or more hits this cycle
hit_count  out  clog2(N_MOLES+1)  number of hits this cycle
miss_pulse  out  1  1-cycle pulse; one or more misses this cycle
miss_count  out  clog2(N_MOLES+1)  number of misses this cycle
game_active  out  1  high in PLAY
game_over  out  1  high in OVER
time_left  out  16  remaining round ticks

Behaviour:
- Reset (async assert, sync release): state IDLE. All outputs 0. time_left=0. All lifetime counters and the spawn counter are 0.
- FSM states:
  - IDLE: start -> PLAY.
  - PLAY: time_left reaches 0 -> OVER.
  - OVER: start -> PLAY. No other exit except reset.
- Entering PLAY: time_left=GAME_MS, spawn counter=SPAWN_MS, moles=0, per-mole counters=0. hit and miss outputs are not asserted on the entry cycle.
- PLAY, on each tick:
  - time_left decrements.
  - The spawn counter decrements; at 0 it reloads SPAWN_MS and a spawn attempt occurs.
  - Every lit mole's counter decrements.
- Spawn attempt:
  - Candidate idx = rng_value mod N_MOLES.
  - If popcount(moles) >= MAX_ACTIVE, no spawn.
  - Otherwise the first unlit slot scanning idx, idx+1, ... with wrap mod N_MOLES is lit, with counter=LIFETIME_MS.
  - A slot hit or expired in the same cycle counts as unlit-but-ineligible and is skipped.
- Expiry: a lit mole whose counter goes 1->0 on a tick is cleared and counts as a miss that cycle.
- Hit: btn_edge[i] & moles[i] clears mole i the same cycle and counts as a hit. Hit beats expiry on the same slot and cycle.
- Whiff: btn_edge[i] & ~moles[i] counts as a miss.
- Per-cycle outputs:
  - hit_count and miss_count are the summed counts for the cycle, registered.
  - hit_pulse = (hit_count != 0) and miss_pulse = (miss_count != 0), registered together with the counts.
  - Latency is 1 cycle from btn_edge to moles cleared and hit_pulse high.
- btn_edge is ignored in IDLE and OVER: no pulses, moles stay 0.
- Transition to OVER: moles cleared immediately. Moles still lit at that point do not generate misses.
- A start pulse during PLAY is ignored.
- Asserting rst_n low mid-round returns everything to reset values asynchronously.
- Arithmetic:
  - The mod uses a compare-subtract loop valid for RNG_W up to 8.
  - Counters saturate at 0 and never wrap.
  - time_left is 0 in IDLE and holds 0 in OVER.

Test Plan:
1. Reset then start. Force rng_value=3 and tick until the first spawn (1000 ticks) -> moles=10'b0000001000, game_active=1, time_left=29000.
2. Spawn with rng_value=3 while slots 3 and 4 are lit (MAX_ACTIVE=3) -> slot 5 lights. A next spawn with 3 lit -> no change to moles.
3. Mole 3 lit. Pulse btn_edge[3] and btn_edge[7] in the same cycle -> next cycle moles[3]=0, hit_count=1, miss_count=1, both pulses high for exactly 1 cycle.
4. Mole lit and untouched for 1500 ticks -> cleared on tick 1500, miss_pulse=1, miss_count=1. btn_edge on that slot in the same cycle instead -> hit_count=1, miss_count=0.
5. Run 30000 ticks -> game_over=1, moles=0, time_left=0. btn_edge afterwards -> no pulses. start -> PLAY with time_left=30000.
6. Drive rst_n low mid-round with moles lit -> moles=0, state IDLE and all outputs 0 without waiting for a clk edge.

Source files
------------

// File: rtl/mole_game_ctrl.sv
// Whack-a-mole round controller: N independent mole slots with random spawns,
// per-mole lifetimes, hit/miss detection and a round timer driven by the ms tick.
module mole_game_ctrl #(
    parameter int N_MOLES     = 10,
    parameter int MAX_ACTIVE  = 3,
    parameter int LIFETIME_MS = 1500,
    parameter int SPAWN_MS    = 1000,
    parameter int GAME_MS     = 30000,
    parameter int RNG_W       = 5
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         tick,
    input  logic                         start,
    input  logic [RNG_W-1:0]             rng_value,
    input  logic [N_MOLES-1:0]           btn_edge,
    output logic [N_MOLES-1:0]           moles,
    output logic                         hit_pulse,
    output logic [$clog2(N_MOLES+1)-1:0] hit_count,
    output logic                         miss_pulse,
    output logic [$clog2(N_MOLES+1)-1:0] miss_count,
    output logic                         game_active,
    output logic                         game_over,
    output logic [15:0]                  time_left
);

    localparam int CW        = $clog2(N_MOLES + 1);
    localparam int IW        = $clog2(N_MOLES);
    localparam int LW        = $clog2(LIFETIME_MS + 1);
    localparam int SW        = $clog2(SPAWN_MS + 1);
    localparam int MOD_ITERS = (2 ** RNG_W) / N_MOLES;

    typedef enum logic [1:0] {
        IDLE,
        PLAY,
        OVER
    } state_t;

    state_t             state;
    logic [LW-1:0]      life    [N_MOLES];
    logic [LW-1:0]      life_nx [N_MOLES];
    logic [SW-1:0]      spawn_cnt;
    logic [SW-1:0]      spawn_nx;
    logic [15:0]        time_nx;
    logic [N_MOLES-1:0] hit_vec;
    logic [N_MOLES-1:0] whiff_vec;
    logic [N_MOLES-1:0] expire_vec;
    logic [N_MOLES-1:0] spawn_vec;
    logic [N_MOLES-1:0] moles_nx;
    logic               last_tick;
    logic               spawn_now;
    logic               found;
    logic [8:0]         rng_mod;
    logic [IW-1:0]      cand;
    logic [IW:0]        pos;

    function automatic logic [CW-1:0] popcount(input logic [N_MOLES-1:0] v);
        logic [CW-1:0] n;
        n = '0;
        for (int i = 0; i < N_MOLES; i++) begin
            n = n + CW'(v[i]);
        end
        return n;
    endfunction

    // Candidate slot: rng_value mod N_MOLES by repeated compare-subtract.
    always_comb begin
        rng_mod = 9'(rng_value);
        for (int m = 0; m < MOD_ITERS; m++) begin
            if (rng_mod >= 9'(N_MOLES)) begin
                rng_mod = rng_mod - 9'(N_MOLES);
            end
        end
        cand = IW'(rng_mod);
    end

    always_comb begin
        hit_vec    = '0;
        whiff_vec  = '0;
        expire_vec = '0;
        spawn_vec  = '0;
        last_tick  = 1'b0;
        spawn_now  = 1'b0;
        found      = 1'b0;
        pos        = '0;
        time_nx    = time_left;
        spawn_nx   = spawn_cnt;
        for (int i = 0; i < N_MOLES; i++) begin
            life_nx[i] = life[i];
        end

        if (state == PLAY) begin
            hit_vec   = btn_edge & moles;
            whiff_vec = btn_edge & ~moles;
            if (tick) begin
                time_nx   = (time_left != 16'd0) ? time_left - 16'd1 : 16'd0;
                last_tick = (time_left <= 16'd1);
                if (spawn_cnt <= SW'(1)) begin
                    spawn_nx  = SW'(SPAWN_MS);
                    spawn_now = 1'b1;
                end else begin
                    spawn_nx = spawn_cnt - SW'(1);
                end
                // Moles still lit when the round ends vanish without counting as misses.
                for (int i = 0; i < N_MOLES; i++) begin
                    if (moles[i]) begin
                        if (life[i] != '0) begin
                            life_nx[i] = life[i] - LW'(1);
                        end
                        if (life[i] == LW'(1) && !hit_vec[i] && !last_tick) begin
                            expire_vec[i] = 1'b1;
                        end
                    end
                end
            end

            for (int i = 0; i < N_MOLES; i++) begin
                if (hit_vec[i] || expire_vec[i]) begin
                    life_nx[i] = '0;
                end
            end

            // Slots hit or expiring this cycle are still set in moles, so the scan skips them.
            if (spawn_now && (popcount(moles) < CW'(MAX_ACTIVE))) begin
                for (int k = 0; k < N_MOLES; k++) begin
                    pos = {1'b0, cand} + (IW + 1)'(k);
                    if (pos >= (IW + 1)'(N_MOLES)) begin
                        pos = pos - (IW + 1)'(N_MOLES);
                    end
                    if (!found && !moles[pos[IW-1:0]]) begin
                        found                  = 1'b1;
                        spawn_vec[pos[IW-1:0]] = 1'b1;
                    end
                end
            end

            for (int i = 0; i < N_MOLES; i++) begin
                if (spawn_vec[i]) begin
                    life_nx[i] = LW'(LIFETIME_MS);
                end
            end
        end

        moles_nx = (moles & ~hit_vec & ~expire_vec) | spawn_vec;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            moles       <= '0;
            hit_pulse   <= 1'b0;
            hit_count   <= '0;
            miss_pulse  <= 1'b0;
            miss_count  <= '0;
            game_active <= 1'b0;
            game_over   <= 1'b0;
            time_left   <= '0;
            spawn_cnt   <= '0;
            for (int i = 0; i < N_MOLES; i++) begin
                life[i] <= '0;
            end
        end else begin
            case (state)
                IDLE, OVER: begin
                    hit_pulse  <= 1'b0;
                    hit_count  <= '0;
                    miss_pulse <= 1'b0;
                    miss_count <= '0;
                    moles      <= '0;
                    time_left  <= '0;
                    if (start) begin
                        state       <= PLAY;
                        game_active <= 1'b1;
                        game_over   <= 1'b0;
                        time_left   <= 16'(GAME_MS);
                        spawn_cnt   <= SW'(SPAWN_MS);
                        for (int i = 0; i < N_MOLES; i++) begin
                            life[i] <= '0;
                        end
                    end
                end
                PLAY: begin
                    hit_count  <= popcount(hit_vec);
                    miss_count <= popcount(whiff_vec) + popcount(expire_vec);
                    hit_pulse  <= |hit_vec;
                    miss_pulse <= |(whiff_vec | expire_vec);
                    if (tick && last_tick) begin
                        state       <= OVER;
                        game_active <= 1'b0;
                        game_over   <= 1'b1;
                        moles       <= '0;
                        time_left   <= '0;
                        spawn_cnt   <= '0;
                        for (int i = 0; i < N_MOLES; i++) begin
                            life[i] <= '0;
                        end
                    end else begin
                        moles     <= moles_nx;
                        time_left <= time_nx;
                        spawn_cnt <= spawn_nx;
                        for (int i = 0; i < N_MOLES; i++) begin
                            life[i] <= life_nx[i];
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mole_game_ctrl.sv
// Directed bench for mole_game_ctrl; a shortened spawn interval lets three moles
// be lit at once so the MAX_ACTIVE limit can be reached.
module tb_mole_game_ctrl;

    logic       clk;
    logic       rst_n;
    logic       tick;
    logic       start;
    logic [4:0] rng_value;
    logic [9:0] btn_edge;
    logic [9:0] moles;
    logic       hit_pulse;
    logic [3:0] hit_count;
    logic       miss_pulse;
    logic [3:0] miss_count;
    logic       game_active;
    logic       game_over;
    logic [15:0] time_left;

    int errors = 0;
    int checks = 0;

    mole_game_ctrl #(
        .N_MOLES    (10),
        .MAX_ACTIVE (3),
        .LIFETIME_MS(1500),
        .SPAWN_MS   (400),
        .GAME_MS    (30000),
        .RNG_W      (5)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .tick       (tick),
        .start      (start),
        .rng_value  (rng_value),
        .btn_edge   (btn_edge),
        .moles      (moles),
        .hit_pulse  (hit_pulse),
        .hit_count  (hit_count),
        .miss_pulse (miss_pulse),
        .miss_count (miss_count),
        .game_active(game_active),
        .game_over  (game_over),
        .time_left  (time_left)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // One clock with the given inputs; returns 1 time unit after the edge.
    task automatic applyStimulus(input logic [9:0] b, input logic t, input logic s);
        btn_edge = b;
        tick     = t;
        start    = s;
        @(posedge clk);
        #1;
        btn_edge = '0;
        tick     = 1'b0;
        start    = 1'b0;
    endtask

    task automatic runTicks(input int n);
        tick = 1'b1;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
        tick = 1'b0;
    endtask

    task automatic checkQuiet(input string tag);
        checkOutput({tag, "_hit_pulse"}, 32'(hit_pulse), 32'd0);
        checkOutput({tag, "_miss_pulse"}, 32'(miss_pulse), 32'd0);
    endtask

    initial begin
        rst_n     = 1'b0;
        tick      = 1'b0;
        start     = 1'b0;
        rng_value = 5'd3;
        btn_edge  = '0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_moles", 32'(moles), 32'h000);
        checkOutput("rst_active", 32'(game_active), 32'd0);
        checkOutput("rst_over", 32'(game_over), 32'd0);
        checkOutput("rst_time", 32'(time_left), 32'd0);
        checkOutput("rst_hit_count", 32'(hit_count), 32'd0);
        checkOutput("rst_miss_count", 32'(miss_count), 32'd0);
        checkQuiet("rst");
        rst_n = 1'b1;
        applyStimulus(10'h000, 1'b0, 1'b0);

        applyStimulus(10'h000, 1'b0, 1'b1);
        checkOutput("start_active", 32'(game_active), 32'd1);
        checkOutput("start_time", 32'(time_left), 32'd30000);
        checkOutput("start_moles", 32'(moles), 32'h000);

        runTicks(400);
        checkOutput("spawn1_moles", 32'(moles), 32'h008);
        checkOutput("spawn1_time", 32'(time_left), 32'd29600);
        checkOutput("spawn1_active", 32'(game_active), 32'd1);
        checkQuiet("spawn1");

        runTicks(400);
        checkOutput("spawn2_moles", 32'(moles), 32'h018);
        runTicks(400);
        checkOutput("spawn3_moles", 32'(moles), 32'h038);
        runTicks(400);
        checkOutput("max_active_moles", 32'(moles), 32'h038);
        checkOutput("max_active_time", 32'(time_left), 32'd28400);

        applyStimulus(10'h088, 1'b0, 1'b0);
        checkOutput("hitwhiff_moles", 32'(moles), 32'h030);
        checkOutput("hitwhiff_hit_count", 32'(hit_count), 32'd1);
        checkOutput("hitwhiff_miss_count", 32'(miss_count), 32'd1);
        checkOutput("hitwhiff_hit_pulse", 32'(hit_pulse), 32'd1);
        checkOutput("hitwhiff_miss_pulse", 32'(miss_pulse), 32'd1);
        applyStimulus(10'h000, 1'b0, 1'b0);
        checkQuiet("hitwhiff_after");
        checkOutput("hitwhiff_after_hit_count", 32'(hit_count), 32'd0);

        applyStimulus(10'h000, 1'b0, 1'b1);
        checkOutput("start_in_play_time", 32'(time_left), 32'd28400);
        checkOutput("start_in_play_moles", 32'(moles), 32'h030);

        // Slot 3 respawns at tick 2000; slot 4 reaches its last tick at 2300.
        runTicks(699);
        checkOutput("pre_expire_moles", 32'(moles), 32'h038);
        checkQuiet("pre_expire");
        runTicks(1);
        checkOutput("expire_moles", 32'(moles), 32'h028);
        checkOutput("expire_miss_pulse", 32'(miss_pulse), 32'd1);
        checkOutput("expire_miss_count", 32'(miss_count), 32'd1);
        checkOutput("expire_hit_pulse", 32'(hit_pulse), 32'd0);
        applyStimulus(10'h000, 1'b0, 1'b0);
        checkQuiet("expire_after");

        // Slot 4 respawns at tick 2400; slot 5 expires at 2700 unless hit.
        runTicks(399);
        checkOutput("pre_hitexp_moles", 32'(moles), 32'h038);
        applyStimulus(10'h020, 1'b1, 1'b0);
        checkOutput("hitexp_moles", 32'(moles), 32'h018);
        checkOutput("hitexp_hit_count", 32'(hit_count), 32'd1);
        checkOutput("hitexp_miss_count", 32'(miss_count), 32'd0);
        checkOutput("hitexp_hit_pulse", 32'(hit_pulse), 32'd1);
        checkOutput("hitexp_miss_pulse", 32'(miss_pulse), 32'd0);
        checkOutput("hitexp_time", 32'(time_left), 32'd27300);

        runTicks(27299);
        checkOutput("end_minus1_time", 32'(time_left), 32'd1);
        checkOutput("end_minus1_active", 32'(game_active), 32'd1);
        checkOutput("end_minus1_lit", 32'(moles != 10'h000), 32'd1);
        runTicks(1);
        checkOutput("over_flag", 32'(game_over), 32'd1);
        checkOutput("over_active", 32'(game_active), 32'd0);
        checkOutput("over_moles", 32'(moles), 32'h000);
        checkOutput("over_time", 32'(time_left), 32'd0);
        checkQuiet("over");

        applyStimulus(10'h3ff, 1'b1, 1'b0);
        checkQuiet("over_btn");
        checkOutput("over_btn_moles", 32'(moles), 32'h000);
        runTicks(5);
        checkOutput("over_hold_time", 32'(time_left), 32'd0);
        checkOutput("over_hold_flag", 32'(game_over), 32'd1);

        applyStimulus(10'h3ff, 1'b0, 1'b1);
        checkOutput("restart_active", 32'(game_active), 32'd1);
        checkOutput("restart_over", 32'(game_over), 32'd0);
        checkOutput("restart_time", 32'(time_left), 32'd30000);
        checkOutput("restart_moles", 32'(moles), 32'h000);
        checkQuiet("restart_entry");

        rng_value = 5'd17;
        runTicks(400);
        checkOutput("mod17_moles", 32'(moles), 32'h080);
        rng_value = 5'd29;
        runTicks(400);
        checkOutput("mod29_moles", 32'(moles), 32'h280);
        rng_value = 5'd9;
        runTicks(400);
        checkOutput("wrap_moles", 32'(moles), 32'h281);

        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_rst_moles", 32'(moles), 32'h000);
        checkOutput("async_rst_active", 32'(game_active), 32'd0);
        checkOutput("async_rst_time", 32'(time_left), 32'd0);
        checkOutput("async_rst_over", 32'(game_over), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        applyStimulus(10'h001, 1'b1, 1'b0);
        checkQuiet("idle_btn");
        checkOutput("idle_btn_moles", 32'(moles), 32'h000);
        checkOutput("idle_btn_time", 32'(time_left), 32'd0);
        checkOutput("idle_btn_active", 32'(game_active), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
